// File: rtl/reg8_wr_arbiter.sv
// Round-robin write arbiter in front of one shared load-enabled register.
// Each write runs IDLE -> GRANT -> ACK. Define REG_ARB_LOCK_EN to add the per-requester lock input.
module reg8_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2,
  parameter int W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] din,
`ifdef REG_ARB_LOCK_EN
  input  logic [NREQ-1:0]   lock,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic              ld,
  output logic [IDX_W-1:0]  owner,
  output logic [W-1:0]      q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_ACK   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [W-1:0]     data_q,  data_d;

  logic [IDX_W-1:0] owner_inc;
  logic [IDX_W-1:0] scan_start;
  logic [NREQ-1:0]  req_eff;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;

`ifdef REG_ARB_LOCK_EN
  logic locked_q, locked_d;
  logic unlock_now;
`endif

  assign owner_inc = IDX_W'((int'(owner_q) + 1) % NREQ);

  // Locked mode narrows the candidate set to the owner; releasing it restarts the scan after the owner.
  always_comb begin
    scan_start = ptr_q;
    req_eff    = req;
`ifdef REG_ARB_LOCK_EN
    unlock_now = locked_q && !lock[owner_q];
    if (locked_q && lock[owner_q]) begin
      req_eff = req & (NREQ'(1) << owner_q);
    end else if (unlock_now) begin
      scan_start = owner_inc;
    end
`endif
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(scan_start) + k) % NREQ);
      if (!win_found && req_eff[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // NOTE: every output and next-state variable gets a default before the case, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    gnt     = '0;
    ack     = '0;
    ld      = 1'b0;
`ifdef REG_ARB_LOCK_EN
    locked_d = locked_q;
`endif
    unique case (state_q)
      S_IDLE: begin
`ifdef REG_ARB_LOCK_EN
        if (unlock_now) begin
          locked_d = 1'b0;
          ptr_d    = owner_inc;
        end
`endif
        if (win_found) begin
          owner_d = win_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        gnt = NREQ'(1) << owner_q;
        if (req[owner_q]) begin
          ld      = 1'b1;
          data_d  = din[int'(owner_q)*W +: W];
          state_d = S_ACK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        ack     = NREQ'(1) << owner_q;
        state_d = S_IDLE;
`ifdef REG_ARB_LOCK_EN
        if (lock[owner_q]) begin
          locked_d = 1'b1;
        end else begin
          ptr_d = owner_inc;
        end
`else
        ptr_d = owner_inc;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments only; the reset branch clears all of it, data included.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
`ifdef REG_ARB_LOCK_EN
      locked_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
`ifdef REG_ARB_LOCK_EN
      locked_q <= locked_d;
`endif
    end
  end

  assign owner = owner_q;
  assign q     = data_q;

endmodule

// File: tb/tb_reg8_wr_arbiter.sv
// Scoreboard bench for reg8_wr_arbiter: stimulus pushes expected {ack, q} per write,
// a negedge monitor pops and compares whenever ack is presented.
module tb_reg8_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;
  localparam int W     = 8;

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic [W-1:0]    q;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] din;
  logic [NREQ-1:0]   lock;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic              ld;
  logic [IDX_W-1:0]  owner;
  logic [W-1:0]      q;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  reg8_wr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .din   (din),
`ifdef REG_ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .ack   (ack),
    .ld    (ld),
    .owner (owner),
    .q     (q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [W-1:0] val);
    exp_t e;
    e.ack = NREQ'(1) << idx;
    e.q   = val;
    exp_q.push_back(e);
  endtask

  // Starts in IDLE with req already applied; returns one cycle into the following IDLE.
  task automatic run_write(input int idx, input bit drop);
    tick();
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(NREQ'(1) << idx));
    check("owner", 32'(owner), 32'(idx));
    check("ld", 32'(ld), 32'd1);
    tick();
    if (drop) req = '0;
    tick();
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ack", 32'(ack), 32'(e.ack));
        check("q_at_ack", 32'(q), 32'(e.q));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    din  = '0;
    lock = '0;

    // Reset held for two cycles with every requester active.
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      check("rst_q", 32'(q), 32'd0);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_ld", 32'(ld), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
    end

    // Single request from requester 2; ptr then sits at 3.
    rst = 1'b0;
    req = 4'b0100;
    din[2*W +: W] = 8'h5A;
    push(2, 8'h5A);
    run_write(2, 1'b1);

    // Withdrawal in GRANT: ptr=3 scans 3,0,1 -> winner 1, no load, no ack.
    req = 4'b0010;
    tick();
    req = 4'b0000;
    @(negedge clk);
    check("wd_gnt", 32'(gnt), 32'b0010);
    check("wd_ld", 32'(ld), 32'd0);
    check("wd_q", 32'(q), 32'h5A);
    tick();
    @(negedge clk);
    check("wd_idle_gnt", 32'(gnt), 32'd0);
    check("wd_idle_q", 32'(q), 32'h5A);

    // ptr still 3: scan 3,0,1 picks 1 over 2; ptr becomes 2.
    req = 4'b0110;
    din[1*W +: W] = 8'h3C;
    push(1, 8'h3C);
    run_write(1, 1'b1);

    // ptr=2: scan 2,3 picks 3 over 0; ptr wraps to 0.
    req = 4'b1001;
    din[3*W +: W] = 8'h77;
    push(3, 8'h77);
    run_write(3, 1'b1);

    // Reset during the GRANT cycle of an 8'hFF write aborts it.
    req = 4'b0001;
    din[0*W +: W] = 8'hFF;
    tick();
    @(negedge clk);
    check("ab_gnt", 32'(gnt), 32'b0001);
    check("ab_ld", 32'(ld), 32'd1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("ab_q", 32'(q), 32'd0);
    check("ab_ack", 32'(ack), 32'd0);
    check("ab_gnt_after", 32'(gnt), 32'd0);
    check("ab_owner", 32'(owner), 32'd0);
    rst = 1'b0;
    req = 4'b0000;
    tick();
    @(negedge clk);
    check("ab_ack_next", 32'(ack), 32'd0);
    check("ab_q_next", 32'(q), 32'd0);

    // All four held: 0,1,2,3,0 with 3->0 wrap.
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    push(0, 8'h11);
    push(1, 8'h22);
    push(2, 8'h33);
    push(3, 8'h44);
    push(0, 8'h11);
    run_write(0, 1'b0);
    run_write(1, 1'b0);
    run_write(2, 1'b0);
    run_write(3, 1'b0);
    run_write(0, 1'b1);

`ifdef REG_ARB_LOCK_EN
    // Lock held by 0 for three writes, then released: next grant is 1.
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    req  = 4'b0011;
    lock = 4'b0001;
    din  = {8'h00, 8'h00, 8'hB2, 8'hA1};
    push(0, 8'hA1);
    push(0, 8'hA1);
    push(0, 8'hA1);
    push(1, 8'hB2);
    run_write(0, 1'b0);
    run_write(0, 1'b0);
    run_write(0, 1'b0);
    lock = 4'b0000;
    run_write(1, 1'b1);
`endif

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg8_wr_arbiter.md
Name: reg8_wr_arbiter

Overview:
- Shares one 8-bit load-enabled register among NREQ requesters using round-robin arbitration.
- The block contains the register (q, load strobe, data mux) and sequences each write as request -> grant/load -> acknowledge.
- It sits between several producer blocks and a single shared configuration/data register whose q is broadcast to consumers.

Parameters:
- NREQ, 4, number of requesters; fixed at 4 in this revision.
- IDX_W, 2, width of requester index; must equal clog2(NREQ).
- W, 8, register data width.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester write request, level, held until ack or withdrawn
- din  input  NREQ*W  packed write data; requester i occupies din[i*W +: W]
- gnt  output  NREQ  one-hot grant; high for exactly the GRANT cycle
- ack  output  NREQ  one-hot write-done pulse; high for exactly the ACK cycle
- ld  output  1  internal register load strobe, exported for observation
- owner  output  IDX_W  index of the current or most recent winner
- q  output  W  shared register contents

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: q=0, gnt=0, ack=0, ld=0, owner=0, rr pointer ptr=0, state=IDLE.
- Reset has priority over every other event. Reset mid-transaction aborts it: no ack is issued and q is cleared.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If req==0, stay in IDLE; q holds its value.
  - Otherwise choose winner w, the first i with req[i]=1, scanning ptr, ptr+1, ... modulo NREQ.
  - Register owner<=w and go to GRANT.
- GRANT:
  - gnt[w]=1.
  - If req[w]=1, then ld=1 and q<=din[w] at the end of this cycle; go to ACK.
  - If req[w]=0 (withdrawn), then ld=0, q is unchanged, no ack is issued, ptr is unchanged; go to IDLE.
- ACK:
  - ack[w]=1 and q already shows the new value.
  - ptr<=(w+1) mod NREQ, wrapping 3->0; go to IDLE.
- Latency: req sampled in IDLE at cycle N; gnt at N+1; q and ack valid at N+2; next arbitration at N+3. One write per 3 cycles maximum.
- Requesters hold din stable from req assertion through gnt. The data is captured only in the GRANT cycle.
- A requester still asserting req after its ack is treated as a new request and ranks behind the others via ptr.
- Requests arriving during GRANT or ACK wait; they are not lost while held.
- gnt, ack and ld are always zero or one-hot, never overlapping across requesters.
- ld == |gnt & req in GRANT.

Optional Feature:
- Macro REG_ARB_LOCK_EN.
- When defined:
  - Adds input port lock, width NREQ.
  - If lock[w]=1 during the ACK cycle, the block enters locked mode: ptr is not advanced and IDLE grants only to w.
  - Other requesters are blocked while locked.
  - Locked mode ends in any IDLE cycle where lock[w]=0; normal round-robin then resumes from (w+1) mod NREQ.
  - Reset clears locked mode.
- When undefined: the lock port is absent and arbitration is pure round-robin.

Test Plan:
- rst=1 for 2 cycles with req=4'b1111 -> q=0, gnt=0, ack=0, ld=0, owner=0 throughout reset.
- req=4'b0100, din[2]=8'h5A from idle -> gnt=4'b0100 at +1, ld=1 at +1, q=8'h5A and ack=4'b0100 at +2, ptr=3.
- req=4'b1111 held, distinct din 8'h11/22/33/44 -> grants in order 0,1,2,3,0 every 3 cycles, with q following 11,22,33,44,11 (covers the 3->0 wrap).
- req[1] asserted, then dropped during GRANT -> gnt=4'b0010 for one cycle, ld=0, q unchanged, no ack, next grant still starts search at same ptr.
- rst asserted in GRANT cycle of a write of 8'hFF -> q=0 next cycle, no ack, state IDLE.
- With REG_ARB_LOCK_EN: req=4'b0011, lock[0]=1 for 3 writes -> three consecutive grants to 0; lock[0]->0 -> next grant goes to 1.
